// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with a fixed
// request-to-response latency. It accepts one load or store, holds it for
// LATENCY cycles, then issues a one-cycle rd_ready/wr_ready pulse.
// Optional feature macro: DMEM_MISALIGN_CHK_EN. When it is defined, misaligned
// half/word accesses complete with resp_err=1. When it is undefined,
// misaligned accesses are forced to natural alignment and proceed normally.
module dmem_responder #(
    parameter int DEPTH_WORDS     = 128,
    parameter int LATENCY         = 2,
    parameter int ROB_ENTRY_WIDTH = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_store,
    input  logic [1:0]                 req_size,
    input  logic                       req_unsigned,
    input  logic [31:0]                req_addr,
    input  logic [31:0]                req_wdata,
    input  logic [ROB_ENTRY_WIDTH-1:0] req_tag,
    input  logic                       flush,
    output logic                       rd_ready,
    output logic                       wr_ready,
    output logic [31:0]                rd_data,
    output logic [ROB_ENTRY_WIDTH-1:0] resp_tag,
    output logic                       resp_err
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Cycles spent in WAIT are LATENCY-1; the counter runs down to zero.
    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    logic [1:0]                 state;
    logic [3:0]                 cnt;
    logic                       lat_store;
    logic [1:0]                 lat_size;
    logic                       lat_unsigned;
    logic [IDX_W+1:0]           lat_addr;
    logic [31:0]                lat_wdata;
    logic [ROB_ENTRY_WIDTH-1:0] lat_tag;

    logic [31:0] mem [DEPTH_WORDS];

    logic             accept;
    logic             in_resp;
    logic             pulse;
    logic             misalign;
    logic [IDX_W-1:0] idx;
    logic [1:0]       off;
    logic [31:0]      word;
    logic [31:0]      merged;
    logic [31:0]      load_val;
    logic [7:0]       load_byte;
    logic [15:0]      load_half;

    // Address bits above the word index are ignored, so the array wraps.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:IDX_W+2];

    // A flushed load is refused at the door; stores are post-commit and
    // therefore always accepted.
    assign accept    = req_valid && req_ready && (req_store || !flush);
    assign req_ready = (state == ST_IDLE);
    assign in_resp   = (state == ST_RESP);

    // Request sequencing: IDLE -> (WAIT) -> RESP -> IDLE, plus request capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= 4'd0;
            lat_store    <= 1'b0;
            lat_size     <= 2'b00;
            lat_unsigned <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= 32'd0;
            lat_tag      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        lat_store    <= req_store;
                        lat_size     <= req_size;
                        lat_unsigned <= req_unsigned;
                        lat_addr     <= req_addr[IDX_W+1:0];
                        lat_wdata    <= req_wdata;
                        lat_tag      <= req_tag;
                        if (LATENCY == 1) begin
                            state <= ST_RESP;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (flush && !lat_store) begin
                        state <= ST_IDLE;
                        cnt   <= 4'd0;
                    end else if (cnt == 4'd0) begin
                        state <= ST_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Lane selection, misalignment detection, store merge and load extension.
    // NOTE: every variable gets a default at the top so no latch is inferred.
    always_comb begin
        idx       = lat_addr[IDX_W+1:2];
        off       = 2'b00;
        word      = mem[idx];
        merged    = word;
        load_byte = 8'd0;
        load_half = 16'd0;
        load_val  = word;
`ifdef DMEM_MISALIGN_CHK_EN
        misalign  = ((lat_size == 2'b01) && lat_addr[0]) ||
                    (lat_size[1] && (lat_addr[1:0] != 2'b00));
`else
        misalign  = 1'b0;
`endif
        case (lat_size)
            2'b00: begin
                off       = lat_addr[1:0];
                merged[{off, 3'b000} +: 8] = lat_wdata[7:0];
                load_byte = word[{off, 3'b000} +: 8];
                load_val  = {{24{load_byte[7] & ~lat_unsigned}}, load_byte};
            end
            2'b01: begin
                off       = {lat_addr[1], 1'b0};
                merged[{off[1], 4'b0000} +: 16] = lat_wdata[15:0];
                load_half = word[{off[1], 4'b0000} +: 16];
                load_val  = {{16{load_half[15] & ~lat_unsigned}}, load_half};
            end
            default: begin
                merged   = lat_wdata;
                load_val = word;
            end
        endcase
    end

    // Store commits on the edge that leaves RESP; a dropped or erroring store never writes.
    // NOTE: the array has no reset branch; contents deliberately survive rst.
    always_ff @(posedge clk) begin
        if (in_resp && lat_store && !misalign) begin
            mem[idx] <= merged;
        end
    end

    // Response outputs are decoded from state so an async reset clears them at once.
    assign rd_ready = in_resp && !lat_store && !flush;
    assign wr_ready = in_resp && lat_store;
    assign pulse    = rd_ready || wr_ready;
    assign rd_data  = (rd_ready && !misalign) ? load_val : 32'd0;
    assign resp_tag = pulse ? lat_tag : '0;
`ifdef DMEM_MISALIGN_CHK_EN
    assign resp_err = pulse && misalign;
`else
    assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a LATENCY=2 instance carries most
// scenarios, and a LATENCY=1 instance covers single-cycle response and aliasing.
module tb_dmem_responder;

    localparam int TW = 5;

    typedef struct packed {
        logic          store;
        logic [31:0]   data;
        logic [TW-1:0] tag;
        logic          err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          valid0 = 1'b0, valid1 = 1'b0;
    logic          store = 1'b0, uns = 1'b0, flush = 1'b0;
    logic [1:0]    size = 2'b10;
    logic [31:0]   addr = 32'd0, wdata = 32'd0;
    logic [TW-1:0] tag = '0;
    logic          sel1 = 1'b0;

    logic          ready0, rd0, wr0, err0, ready1, rd1, wr1, err1;
    logic [31:0]   data0, data1;
    logic [TW-1:0] rtag0, rtag1;

    wire           o_ready = sel1 ? ready1 : ready0;
    wire           o_rd    = sel1 ? rd1 : rd0;
    wire           o_wr    = sel1 ? wr1 : wr0;
    wire           o_err   = sel1 ? err1 : err0;
    wire [31:0]    o_data  = sel1 ? data1 : data0;
    wire [TW-1:0]  o_tag   = sel1 ? rtag1 : rtag0;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    dmem_responder #(.DEPTH_WORDS(128), .LATENCY(2), .ROB_ENTRY_WIDTH(TW)) u_dut (
        .clk(clk), .rst(rst), .req_valid(valid0), .req_ready(ready0),
        .req_store(store), .req_size(size), .req_unsigned(uns), .req_addr(addr),
        .req_wdata(wdata), .req_tag(tag), .flush(flush), .rd_ready(rd0),
        .wr_ready(wr0), .rd_data(data0), .resp_tag(rtag0), .resp_err(err0)
    );

    dmem_responder #(.DEPTH_WORDS(128), .LATENCY(1), .ROB_ENTRY_WIDTH(TW)) u_lat1 (
        .clk(clk), .rst(rst), .req_valid(valid1), .req_ready(ready1),
        .req_store(store), .req_size(size), .req_unsigned(uns), .req_addr(addr),
        .req_wdata(wdata), .req_tag(tag), .flush(flush), .rd_ready(rd1),
        .wr_ready(wr1), .rd_data(data1), .resp_tag(rtag1), .resp_err(err1)
    );

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", name, obs, exp);
    endtask

    // One full transaction. fl_mode: 0 none, 1 flush with the request, 2 flush in WAIT.
    task automatic req(input int lat, input logic st, input logic [1:0] sz, input logic un,
                       input logic [31:0] a, input logic [31:0] wd, input logic [TW-1:0] t,
                       input logic [31:0] exp_data, input logic exp_err, input int fl_mode);
        exp_t e;
        @(negedge clk);
        sel1 = (lat == 1);
        chk("req_ready_idle", 32'(o_ready), 32'd1);
        store = st; size = sz; uns = un; addr = a; wdata = wd; tag = t;
        flush = (fl_mode == 1);
        if (lat == 1) valid1 = 1'b1; else valid0 = 1'b1;
        e.store = st; e.data = st ? 32'd0 : exp_data; e.tag = t; e.err = exp_err;
        sb.push_back(e);
        @(posedge clk); #1;
        valid0 = 1'b0; valid1 = 1'b0; flush = 1'b0;
        for (int c = 1; c < lat; c++) begin
            chk("no_pulse_wait", {30'd0, o_rd, o_wr}, 32'd0);
            chk("ready_low_wait", 32'(o_ready), 32'd0);
            flush = (fl_mode == 2) && (c == 1);
            @(posedge clk); #1;
            flush = 1'b0;
        end
        e = sb.pop_front();
        chk("ready_low_resp", 32'(o_ready), 32'd0);
        chk("pulse_kind", {30'd0, o_rd, o_wr}, e.store ? 32'd1 : 32'd2);
        chk("rd_data", o_data, e.data);
        chk("resp_tag", 32'(o_tag), 32'(e.tag));
        chk("resp_err", 32'(o_err), 32'(e.err));
        @(posedge clk); #1;
        chk("ready_back", 32'(o_ready), 32'd1);
        chk("quiet_after", {29'd0, o_rd, o_wr, o_err}, 32'd0);
        chk("tag_zero_after", 32'(o_tag), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        #12;
        chk("rst_ready", 32'(ready0), 32'd1);
        chk("rst_ready_l1", 32'(ready1), 32'd1);
        chk("rst_pulses", {29'd0, rd0, wr0, err0}, 32'd0);
        chk("rst_data", data0, 32'd0);
        chk("rst_tag", 32'(rtag0), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic word store/load with tag echo.
        req(2, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 5'd3, 32'd0, 1'b0, 0);
        req(2, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 5'd7, 32'hDEADBEEF, 1'b0, 0);

        // Byte merge and sign/zero extension.
        req(2, 1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 5'd1, 32'd0, 1'b0, 0);
        req(2, 1'b1, 2'b00, 1'b0, 32'h13, 32'h00000080, 5'd2, 32'd0, 1'b0, 0);
        req(2, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 5'd4, 32'h80223344, 1'b0, 0);
        req(2, 1'b0, 2'b00, 1'b0, 32'h13, 32'd0, 5'd5, 32'hFFFFFF80, 1'b0, 0);
        req(2, 1'b0, 2'b00, 1'b1, 32'h13, 32'd0, 5'd6, 32'h00000080, 1'b0, 0);
        req(2, 1'b0, 2'b01, 1'b0, 32'h12, 32'd0, 5'd8, 32'hFFFF8022, 1'b0, 0);
        req(2, 1'b0, 2'b01, 1'b1, 32'h10, 32'd0, 5'd9, 32'h00003344, 1'b0, 0);
        req(2, 1'b0, 2'b11, 1'b0, 32'h10, 32'd0, 5'd10, 32'h80223344, 1'b0, 0);
        req(2, 1'b0, 2'b10, 1'b0, 32'h210, 32'd0, 5'd12, 32'h80223344, 1'b0, 0);
        req(2, 1'b0, 2'b10, 1'b0, 32'hFFFFFE10, 32'd0, 5'd13, 32'h80223344, 1'b0, 0);
        req(2, 1'b1, 2'b01, 1'b0, 32'h10, 32'hAAAA7FFF, 5'd14, 32'd0, 1'b0, 0);
        req(2, 1'b0, 2'b01, 1'b0, 32'h10, 32'd0, 5'd15, 32'h00007FFF, 1'b0, 0);
        req(2, 1'b0, 2'b00, 1'b1, 32'h12, 32'd0, 5'd16, 32'h00000022, 1'b0, 0);

        // Load flushed in WAIT: abandoned, responder idle on the next cycle.
        @(negedge clk);
        sel1 = 1'b0; store = 1'b0; size = 2'b10; addr = 32'h10; tag = 5'd11; valid0 = 1'b1;
        @(posedge clk); #1;
        valid0 = 1'b0;
        chk("flush_ld_accepted", 32'(ready0), 32'd0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_ld_no_rd", {30'd0, rd0, wr0}, 32'd0);
        chk("flush_ld_ready", 32'(ready0), 32'd1);
        @(posedge clk); #1;
        chk("flush_ld_still_quiet", {30'd0, rd0, wr0}, 32'd0);

        // Store flushed in WAIT completes and writes.
        req(2, 1'b1, 2'b10, 1'b0, 32'h30, 32'h0BADF00D, 5'd17, 32'd0, 1'b0, 2);
        req(2, 1'b0, 2'b10, 1'b0, 32'h30, 32'd0, 5'd18, 32'h0BADF00D, 1'b0, 0);

        // Flush coincident with a load request in IDLE: refused.
        @(negedge clk);
        store = 1'b0; addr = 32'h30; valid0 = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        valid0 = 1'b0; flush = 1'b0;
        chk("flush_idle_ld_refused", 32'(ready0), 32'd1);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("flush_idle_ld_quiet", {30'd0, rd0, wr0}, 32'd0);
        end
        // Flush coincident with a store request: accepted and written.
        req(2, 1'b1, 2'b10, 1'b0, 32'h34, 32'h13579BDF, 5'd19, 32'd0, 1'b0, 1);
        req(2, 1'b0, 2'b10, 1'b0, 32'h34, 32'd0, 5'd20, 32'h13579BDF, 1'b0, 0);

        // Async reset mid-WAIT of a store: dropped, no write.
        req(2, 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, 5'd21, 32'd0, 1'b0, 0);
        @(negedge clk);
        store = 1'b1; size = 2'b10; addr = 32'h20; wdata = 32'h5; tag = 5'd22; valid0 = 1'b1;
        @(posedge clk); #1;
        valid0 = 1'b0;
        chk("rst_mid_wait_busy", 32'(ready0), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_ready", 32'(ready0), 32'd1);
        chk("rst_mid_pulses", {29'd0, rd0, wr0, err0}, 32'd0);
        chk("rst_mid_tag", 32'(rtag0), 32'd0);
        #1 rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("rst_mid_no_wr", {30'd0, rd0, wr0}, 32'd0);
        end
        req(2, 1'b0, 2'b10, 1'b0, 32'h20, 32'd0, 5'd23, 32'hCAFEF00D, 1'b0, 0);

        // Misaligned accesses.
`ifdef DMEM_MISALIGN_CHK_EN
        req(2, 1'b1, 2'b10, 1'b0, 32'h22, 32'h12345678, 5'd24, 32'd0, 1'b1, 0);
        req(2, 1'b0, 2'b10, 1'b0, 32'h20, 32'd0, 5'd25, 32'hCAFEF00D, 1'b0, 0);
        req(2, 1'b0, 2'b01, 1'b0, 32'h23, 32'd0, 5'd26, 32'h00000000, 1'b1, 0);
`else
        req(2, 1'b1, 2'b10, 1'b0, 32'h22, 32'h12345678, 5'd24, 32'd0, 1'b0, 0);
        req(2, 1'b0, 2'b10, 1'b0, 32'h20, 32'd0, 5'd25, 32'h12345678, 1'b0, 0);
        req(2, 1'b0, 2'b01, 1'b0, 32'h23, 32'd0, 5'd26, 32'h00001234, 1'b0, 0);
`endif

        // LATENCY=1 instance: next-cycle response and address aliasing.
        req(1, 1'b1, 2'b10, 1'b0, 32'h210, 32'h600DCAFE, 5'd27, 32'd0, 1'b0, 0);
        req(1, 1'b0, 2'b10, 1'b0, 32'h010, 32'd0, 5'd28, 32'h600DCAFE, 1'b0, 0);
        req(1, 1'b0, 2'b00, 1'b0, 32'h013, 32'd0, 5'd29, 32'h00000060, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
